// File: rtl/pmc_bank.sv
// pmc_bank -- parametrised bank of performance-monitoring counters.
//
// Each counter counts one runtime-selected bit of event_vec while global_run
// and its own enable are high. It either wraps or saturates on overflow and
// keeps a sticky overflow flag. snap_req freezes every live count and flag
// into snapshot registers in the same cycle. Software reads the snapshots
// through rd_idx, which keeps multi-counter reads coherent.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   event_vec    one-cycle event strobes, one bit per source
//   global_run   1 = counting allowed, 0 = all counters hold
//   cfg_we       configuration write strobe
//   cfg_idx      counter being configured (out-of-range index is ignored)
//   cfg_evt_sel  event source for counter cfg_idx
//   cfg_en       enable for counter cfg_idx
//   clear        zeroes all live counts and overflow flags
//   snap_req     capture all live counters into the snapshots
//   rd_idx       snapshot index to read
//   rd_data      registered snapshot[rd_idx] (0 when out of range)
//   rd_ovf       registered overflow flag captured with snapshot[rd_idx]
//   snap_valid   snapshots hold captured data
//   ovf_any      registered OR of all live sticky overflow flags
module pmc_bank #(
  parameter int NUM_CNT  = 4,
  parameter int CNT_W    = 32,
  parameter int NUM_EVT  = 8,
  parameter int SAT_MODE = 0,
  localparam int IDX_W   = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
  localparam int EVT_W   = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_EVT-1:0] event_vec,
  input  logic               global_run,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [EVT_W-1:0]   cfg_evt_sel,
  input  logic               cfg_en,
  input  logic               clear,
  input  logic               snap_req,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [CNT_W-1:0]   rd_data,
  output logic               rd_ovf,
  output logic               snap_valid,
  output logic               ovf_any
);

  // Per-counter live state and snapshots
  logic [CNT_W-1:0] cnt_q      [NUM_CNT];
  logic             ovf_q      [NUM_CNT];
  logic [EVT_W-1:0] sel_q      [NUM_CNT];
  logic             en_q       [NUM_CNT];
  logic [CNT_W-1:0] snap_q     [NUM_CNT];
  logic             snap_ovf_q [NUM_CNT];

  // Next-cycle overflow flags, gathered for the registered ovf_any
  logic [NUM_CNT-1:0] ovf_next;

  logic               snap_valid_q;
  logic [CNT_W-1:0]   rd_data_q;
  logic [CNT_W-1:0]   rd_data_d;
  logic               rd_ovf_q;
  logic               rd_ovf_d;
  logic               ovf_any_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic             evt_hit;
      logic             cfg_hit;
      logic             inc;
      logic [CNT_W-1:0] cnt_d;
      logic             ovf_d;
      logic [EVT_W-1:0] sel_d;
      logic             en_d;

      // Mux the selected event bit; a selection beyond NUM_EVT sees no events.
      always_comb begin
        evt_hit = 1'b0;
        for (int e = 0; e < NUM_EVT; e++) begin
          if (sel_q[gi] == EVT_W'(e)) begin
            evt_hit = event_vec[e];
          end
        end
      end

      assign cfg_hit = cfg_we && (cfg_idx == IDX_W'(gi));
      // Uses the selection/enable held before this edge, so a config write
      // only governs increments from the following cycle on.
      assign inc     = global_run && en_q[gi] && evt_hit;

      always_comb begin
        cnt_d = cnt_q[gi];
        ovf_d = ovf_q[gi];
        sel_d = sel_q[gi];
        en_d  = en_q[gi];
        if (cfg_hit) begin
          sel_d = cfg_evt_sel;
          en_d  = cfg_en;
        end
        if (clear) begin
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (cfg_hit) begin
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (inc) begin
          if (&cnt_q[gi]) begin
            ovf_d = 1'b1;
            cnt_d = (SAT_MODE != 0) ? cnt_q[gi] : '0;
          end else begin
            cnt_d = cnt_q[gi] + CNT_W'(1);
          end
        end
      end

      assign ovf_next[gi] = ovf_d;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_q[gi]      <= '0;
          ovf_q[gi]      <= 1'b0;
          sel_q[gi]      <= EVT_W'(gi % NUM_EVT);
          en_q[gi]       <= 1'b0;
          snap_q[gi]     <= '0;
          snap_ovf_q[gi] <= 1'b0;
        end else begin
          cnt_q[gi] <= cnt_d;
          ovf_q[gi] <= ovf_d;
          sel_q[gi] <= sel_d;
          en_q[gi]  <= en_d;
          // Capture the pre-edge live values: same-cycle increments and
          // clears are not visible in the snapshot.
          if (snap_req) begin
            snap_q[gi]     <= cnt_q[gi];
            snap_ovf_q[gi] <= ovf_q[gi];
          end
        end
      end
    end
  endgenerate

  // Read mux over the stored snapshots; an out-of-range index reads 0/0.
  // A capture at the same edge is not visible until the next read.
  always_comb begin
    rd_data_d = '0;
    rd_ovf_d  = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data_d = snap_q[i];
        rd_ovf_d  = snap_ovf_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_valid_q <= 1'b0;
      rd_data_q    <= '0;
      rd_ovf_q     <= 1'b0;
      ovf_any_q    <= 1'b0;
    end else begin
      snap_valid_q <= snap_valid_q | snap_req;
      rd_data_q    <= rd_data_d;
      rd_ovf_q     <= rd_ovf_d;
      ovf_any_q    <= |ovf_next;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_ovf     = rd_ovf_q;
  assign snap_valid = snap_valid_q;
  assign ovf_any    = ovf_any_q;

endmodule

// File: tb/tb_pmc_bank.sv
// tb_pmc_bank -- scoreboard bench for pmc_bank.
//
// Two instances share all stimulus: one wrapping, one saturating, both with
// 4-bit counters so overflow is reached quickly. A behavioural model turns
// every driven cycle into an expected output set, pushed into a queue; a
// separate monitor pops one entry after each clock edge and compares it.
module tb_pmc_bank;

  localparam int NC   = 4;
  localparam int CW   = 4;
  localparam int NE   = 8;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NE-1:0] event_vec = '0;
  logic          global_run = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_idx = '0;
  logic [2:0]    cfg_evt_sel = '0;
  logic          cfg_en = 1'b0;
  logic          clear = 1'b0;
  logic          snap_req = 1'b0;
  logic [1:0]    rd_idx = '0;

  logic [CW-1:0] rd_data_w, rd_data_s;
  logic          rd_ovf_w, rd_ovf_s;
  logic          snap_valid_w, snap_valid_s;
  logic          ovf_any_w, ovf_any_s;

  always #5 clk = ~clk;

  pmc_bank #(.NUM_CNT(NC), .CNT_W(CW), .NUM_EVT(NE), .SAT_MODE(0)) u_wrap (
    .clk(clk), .reset(reset), .event_vec(event_vec), .global_run(global_run),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_evt_sel(cfg_evt_sel), .cfg_en(cfg_en),
    .clear(clear), .snap_req(snap_req), .rd_idx(rd_idx),
    .rd_data(rd_data_w), .rd_ovf(rd_ovf_w), .snap_valid(snap_valid_w), .ovf_any(ovf_any_w)
  );

  pmc_bank #(.NUM_CNT(NC), .CNT_W(CW), .NUM_EVT(NE), .SAT_MODE(1)) u_sat (
    .clk(clk), .reset(reset), .event_vec(event_vec), .global_run(global_run),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_evt_sel(cfg_evt_sel), .cfg_en(cfg_en),
    .clear(clear), .snap_req(snap_req), .rd_idx(rd_idx),
    .rd_data(rd_data_s), .rd_ovf(rd_ovf_s), .snap_valid(snap_valid_s), .ovf_any(ovf_any_s)
  );

  typedef struct packed {
    logic [1:0][CW-1:0] rd;   // [0] = wrap instance, [1] = saturating
    logic [1:0]         ovf;
    logic [1:0]         sv;
    logic [1:0]         oa;
    logic [1:0]         idx;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   txn = 0;

  // Reference model: plain integer counts per instance (0 = wrap, 1 = sat)
  int m_cnt  [2][NC];
  bit m_ovf  [2][NC];
  int m_snap [2][NC];
  bit m_sovf [2][NC];
  int m_sel  [NC];
  bit m_en   [NC];
  bit m_sv;

  task automatic chk(input string name, input int m, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s dut=%s actual=%0d required=%0d t=%0t",
               name, (m != 0) ? "sat" : "wrap", act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      for (int m = 0; m < 2; m++) begin
        m_cnt[m][i]  = 0;
        m_ovf[m][i]  = 1'b0;
        m_snap[m][i] = 0;
        m_sovf[m][i] = 1'b0;
      end
      m_sel[i] = i % NE;
      m_en[i]  = 1'b0;
    end
    m_sv = 1'b0;
  endtask

  // Apply the currently driven inputs to the model, queue the outputs the
  // DUT must show after the coming edge, then advance to the next negedge.
  task automatic cycle();
    exp_t e;
    bit   inc, wr;
    int   nxt;
    e     = '0;
    e.idx = rd_idx;
    for (int m = 0; m < 2; m++) begin
      e.rd[m]  = CW'(m_snap[m][rd_idx]);
      e.ovf[m] = m_sovf[m][rd_idx];
      e.sv[m]  = m_sv | snap_req;
    end
    m_sv = m_sv | snap_req;
    if (snap_req) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < NC; i++) begin
          m_snap[m][i] = m_cnt[m][i];
          m_sovf[m][i] = m_ovf[m][i];
        end
      end
    end
    for (int i = 0; i < NC; i++) begin
      inc = global_run && m_en[i] && event_vec[m_sel[i]];
      wr  = cfg_we && (int'(cfg_idx) == i);
      for (int m = 0; m < 2; m++) begin
        if (clear || wr) begin
          m_cnt[m][i] = 0;
          m_ovf[m][i] = 1'b0;
        end else if (inc) begin
          nxt = m_cnt[m][i] + 1;
          if (nxt > MAXV) begin
            m_ovf[m][i] = 1'b1;
            m_cnt[m][i] = (m == 1) ? MAXV : nxt % (MAXV + 1);
          end else begin
            m_cnt[m][i] = nxt;
          end
        end
      end
      if (wr) begin
        m_sel[i] = int'(cfg_evt_sel);
        m_en[i]  = cfg_en;
      end
    end
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NC; i++) begin
        if (m_ovf[m][i]) e.oa[m] = 1'b1;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    event_vec = '0;
    cfg_we    = 1'b0;
    clear     = 1'b0;
    snap_req  = 1'b0;
  endtask

  task automatic cfg(input int idx, input int sel, input bit en);
    set_idle();
    cfg_we      = 1'b1;
    cfg_idx     = 2'(idx);
    cfg_evt_sel = 3'(sel);
    cfg_en      = en;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic events(input int bitpos, input int n);
    set_idle();
    for (int k = 0; k < n; k++) begin
      event_vec = NE'(1 << bitpos);
      cycle();
    end
    event_vec = '0;
  endtask

  task automatic snap_then_read(input int idx);
    set_idle();
    snap_req = 1'b1;
    cycle();
    snap_req = 1'b0;
    rd_idx   = 2'(idx);
    cycle();
  endtask

  task automatic read_idx(input int idx);
    set_idle();
    rd_idx = 2'(idx);
    cycle();
  endtask

  // Monitor: outputs are registered, so one queued expectation per edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        chk("rd_data",    0, int'(rd_data_w),    int'(e.rd[0]));
        chk("rd_data",    1, int'(rd_data_s),    int'(e.rd[1]));
        chk("rd_ovf",     0, int'(rd_ovf_w),     int'(e.ovf[0]));
        chk("rd_ovf",     1, int'(rd_ovf_s),     int'(e.ovf[1]));
        chk("snap_valid", 0, int'(snap_valid_w), int'(e.sv[0]));
        chk("snap_valid", 1, int'(snap_valid_s), int'(e.sv[1]));
        chk("ovf_any",    0, int'(ovf_any_w),    int'(e.oa[0]));
        chk("ovf_any",    1, int'(ovf_any_s),    int'(e.oa[1]));
        $display("txn %0d idx=%0d rd_w=%0d rd_s=%0d ovf=%b%b sv=%b%b oa=%b%b",
                 txn, e.idx, rd_data_w, rd_data_s, rd_ovf_w, rd_ovf_s,
                 snap_valid_w, snap_valid_s, ovf_any_w, ovf_any_s);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_data"},    0, int'(rd_data_w), 0);
    chk({tag, "_rd_data"},    1, int'(rd_data_s), 0);
    chk({tag, "_rd_ovf"},     0, int'(rd_ovf_w), 0);
    chk({tag, "_rd_ovf"},     1, int'(rd_ovf_s), 0);
    chk({tag, "_snap_valid"}, 0, int'(snap_valid_w), 0);
    chk({tag, "_snap_valid"}, 1, int'(snap_valid_s), 0);
    chk({tag, "_ovf_any"},    0, int'(ovf_any_w), 0);
    chk({tag, "_ovf_any"},    1, int'(ovf_any_s), 0);
  endtask

  initial begin : stimulus
    model_reset();
    #1 reset = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Basic counting: counter0 counts bit 2 only
    global_run = 1'b1;
    cfg(0, 2, 1'b1);
    events(2, 5);
    events(3, 3);
    snap_then_read(0);
    chk("basic_count", 0, int'(rd_data_w), 5);
    for (int i = 1; i < NC; i++) begin
      read_idx(i);
      chk("disabled_cnt", 0, int'(rd_data_w), 0);
    end

    // 17 events on a 4-bit counter: wrap gives 1, saturate gives 15
    set_idle(); clear = 1'b1; cycle(); clear = 1'b0;
    events(2, 17);
    snap_then_read(0);
    chk("wrap_value", 0, int'(rd_data_w), 1);
    chk("sat_value",  1, int'(rd_data_s), MAXV);
    chk("wrap_ovf",   0, int'(rd_ovf_w), 1);
    chk("ovf_any",    0, int'(ovf_any_w), 1);

    // Snapshot excludes the same-cycle increment; read of the index being
    // captured returns the old snapshot
    set_idle(); clear = 1'b1; cycle(); clear = 1'b0;
    events(2, 7);
    set_idle(); event_vec = 8'h04; snap_req = 1'b1; rd_idx = 2'd0; cycle();
    set_idle(); snap_req = 1'b1; cycle();
    chk("snap_excl_inc", 0, int'(rd_data_w), 7);
    set_idle(); cycle();
    chk("snap_next", 0, int'(rd_data_w), 8);

    // clear and snap_req together: snapshot keeps 9, live goes to 0
    cfg(1, 5, 1'b1);
    events(5, 9);
    set_idle(); clear = 1'b1; snap_req = 1'b1; cycle();
    read_idx(1);
    chk("clear_snap", 0, int'(rd_data_w), 9);
    snap_then_read(1);
    chk("after_clear", 0, int'(rd_data_w), 0);
    chk("ovf_any_clr", 0, int'(ovf_any_w), 0);

    // global_run gating, then a mid-run config write to counter2
    cfg(2, 6, 1'b1);
    global_run = 1'b0;
    for (int k = 0; k < 4; k++) begin set_idle(); event_vec = 8'h44; cycle(); end
    global_run = 1'b1;
    for (int k = 0; k < 2; k++) begin set_idle(); event_vec = 8'h44; cycle(); end
    snap_then_read(2);
    chk("run_gate", 0, int'(rd_data_w), 2);
    set_idle(); event_vec = 8'h44; cfg_we = 1'b1; cfg_idx = 2'd2;
    cfg_evt_sel = 3'd6; cfg_en = 1'b1; cycle();
    snap_then_read(0);
    chk("cfg_keeps_c0", 0, int'(rd_data_w), 3);
    read_idx(2);
    chk("cfg_zeroes_c2", 0, int'(rd_data_w), 0);

    // Randomised traffic
    for (int i = 0; i < NC; i++) cfg(i, i, 1'b1);
    for (int k = 0; k < 500; k++) begin
      event_vec   = NE'($urandom);
      global_run  = ($urandom_range(0, 7) != 0);
      cfg_we      = ($urandom_range(0, 15) == 0);
      cfg_idx     = 2'($urandom);
      cfg_evt_sel = 3'($urandom);
      cfg_en      = ($urandom_range(0, 3) != 0);
      clear       = ($urandom_range(0, 31) == 0);
      snap_req    = ($urandom_range(0, 3) == 0);
      rd_idx      = 2'($urandom);
      cycle();
    end

    // Asynchronous reset between edges, then no counting until reconfigured
    set_idle(); global_run = 1'b1; event_vec = '1; snap_req = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    set_idle(); global_run = 1'b1;
    for (int k = 0; k < 4; k++) begin event_vec = '1; cycle(); end
    for (int i = 0; i < NC; i++) begin
      snap_then_read(i);
      chk("post_reset_cnt", 0, int'(rd_data_w), 0);
    end

    set_idle();
    @(posedge clk);
    #2;
    chk("queue_drained", 0, exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound so a stuck run still reports
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
